am_query_arbiter: RTL



---
 rtl/am_query_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/am_query_arbiter.sv
// am_query_arbiter
//
// Shares one associative memory (AM) between NUM_REQ query sources. A
// round-robin arbiter picks one requester, its query hypervector is issued to
// the AM, the label/distance result is awaited under a watchdog, and the
// result is returned to the consumer tagged with the requester ID. Only one
// query is in flight at a time.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
// Clk_CI edge where valid and ready are both high. A source holds valid and
// its data stable until the transfer. A sink may raise ready independently of
// valid.
//
// Ports:
//   Clk_CI, Reset_RI             clock, synchronous active-high reset
//   ReqValid_SI / ReqReady_SO    per-requester query handshake
//   ReqHypervector_DI            query vectors, requester i at [i*HV_DIM +: HV_DIM]
//   AmValid_SO / AmReady_SI      query handshake towards the AM
//   AmHypervector_DO             query vector towards the AM
//   AmValid_SI / AmReady_SO      result handshake from the AM
//   AmLabel_*_DI, AmDistance_*_DI  AM result
//   RspValid_SO / RspReady_SI    response handshake towards the consumer
//   RspId_DO, RspError_DO, RspLabel_*_DO, RspDistance_*_DO  response payload
//   Busy_SO                      high whenever the FSM is not IDLE
//   DbgState_DO                  current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESPOND)
module am_query_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ID_WIDTH       = 2,
  parameter int HV_DIM         = 2000,
  parameter int LABEL_WIDTH    = 1,
  parameter int DISTANCE_WIDTH = 11,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                        Clk_CI,
  input  logic                        Reset_RI,
  input  logic [NUM_REQ-1:0]          ReqValid_SI,
  output logic [NUM_REQ-1:0]          ReqReady_SO,
  input  logic [NUM_REQ*HV_DIM-1:0]   ReqHypervector_DI,
  output logic                        AmValid_SO,
  input  logic                        AmReady_SI,
  output logic [HV_DIM-1:0]           AmHypervector_DO,
  input  logic                        AmValid_SI,
  output logic                        AmReady_SO,
  input  logic [LABEL_WIDTH-1:0]      AmLabel_A_DI,
  input  logic [LABEL_WIDTH-1:0]      AmLabel_V_DI,
  input  logic [DISTANCE_WIDTH-1:0]   AmDistance_A_DI,
  input  logic [DISTANCE_WIDTH-1:0]   AmDistance_V_DI,
  output logic                        RspValid_SO,
  input  logic                        RspReady_SI,
  output logic [ID_WIDTH-1:0]         RspId_DO,
  output logic                        RspError_DO,
  output logic [LABEL_WIDTH-1:0]      RspLabel_A_DO,
  output logic [LABEL_WIDTH-1:0]      RspLabel_V_DO,
  output logic [DISTANCE_WIDTH-1:0]   RspDistance_A_DO,
  output logic [DISTANCE_WIDTH-1:0]   RspDistance_V_DO,
  output logic                        Busy_SO,
  output logic [1:0]                  DbgState_DO
);

  localparam int WD_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [ID_WIDTH-1:0]  ptr_q;
  logic [ID_WIDTH-1:0]  id_q;
  logic [HV_DIM-1:0]    query_q;
  logic [WD_WIDTH-1:0]  wd_q;

  logic [ID_WIDTH-1:0]  sel_id;
  logic                 sel_found;
  int                   sel_idx;
  logic                 accept;
  logic                 wd_expired;

  // Round-robin search starting just after the last granted requester.
  // Recomputed every cycle, so a requester may drop valid before its grant.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    sel_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sel_idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!sel_found && ReqValid_SI[sel_idx]) begin
        sel_found = 1'b1;
        sel_id    = ID_WIDTH'(sel_idx);
      end
    end
  end

  // ReqReady is only raised for the selected requester, whose valid is set,
  // so the request handshake reduces to "IDLE with something selected".
  assign accept     = (state_q == S_IDLE) && sel_found;
  assign wd_expired = (wd_q == WD_LAST);

  // State register
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept)                    state_d = S_ISSUE;
      S_ISSUE:   if (AmReady_SI)                state_d = S_WAIT;
      S_WAIT:    if (AmValid_SI || wd_expired)  state_d = S_RESPOND;
      S_RESPOND: if (RspReady_SI)               state_d = S_IDLE;
      default:                                  state_d = S_IDLE;
    endcase
  end

  // Output decode. AmReady_SO is also high in IDLE and RESPOND so that a late
  // AM result arriving after a timeout is drained; it is simply not captured.
  always_comb begin
    ReqReady_SO = '0;
    AmValid_SO  = 1'b0;
    AmReady_SO  = 1'b0;
    RspValid_SO = 1'b0;
    case (state_q)
      S_IDLE: begin
        AmReady_SO = 1'b1;
        if (sel_found) ReqReady_SO = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_id;
      end
      S_ISSUE:   AmValid_SO = 1'b1;
      S_WAIT:    AmReady_SO = 1'b1;
      S_RESPOND: begin
        AmReady_SO  = 1'b1;
        RspValid_SO = 1'b1;
      end
      default: ;
    endcase
  end

  assign Busy_SO          = (state_q != S_IDLE);
  assign DbgState_DO      = state_q;
  assign AmHypervector_DO = query_q;
  assign RspId_DO         = id_q;

  // Datapath registers
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      ptr_q            <= ID_WIDTH'(NUM_REQ - 1);
      id_q             <= '0;
      query_q          <= '0;
      wd_q             <= '0;
      RspError_DO      <= 1'b0;
      RspLabel_A_DO    <= '0;
      RspLabel_V_DO    <= '0;
      RspDistance_A_DO <= '1;
      RspDistance_V_DO <= '1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            query_q <= ReqHypervector_DI[int'(sel_id)*HV_DIM +: HV_DIM];
            id_q    <= sel_id;
            ptr_q   <= sel_id;
          end
        end
        S_ISSUE: begin
          if (AmReady_SI) wd_q <= '0;
        end
        S_WAIT: begin
          // A result in the final watchdog cycle still wins over the timeout.
          if (AmValid_SI) begin
            RspError_DO      <= 1'b0;
            RspLabel_A_DO    <= AmLabel_A_DI;
            RspLabel_V_DO    <= AmLabel_V_DI;
            RspDistance_A_DO <= AmDistance_A_DI;
            RspDistance_V_DO <= AmDistance_V_DI;
          end else if (wd_expired) begin
            RspError_DO      <= 1'b1;
            RspLabel_A_DO    <= '0;
            RspLabel_V_DO    <= '0;
            RspDistance_A_DO <= '1;
            RspDistance_V_DO <= '1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
